// File: rtl/sm3_unpadding.sv
// Strips SM3 single-block padding: validates the marker/length layout of a
// 512-bit block and streams the recovered message bytes out MSB-first.
module sm3_unpadding #(
   parameter int MAX_BYTES = 55
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:511] messageBlock,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:7]   out_byte,
   output logic         out_last,
   output logic         done,
   output logic         err,
   output logic [0:63]  msg_len
);

   localparam logic [8:0] MAX_BITS = 9'(8 * MAX_BYTES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t       state_q;
   logic [0:511] blk_q;
   logic [5:0]   idx_q;
   logic [5:0]   last_idx_q;
   logic         in_ready_q;
   logic         out_valid_q;
   logic [0:7]   out_byte_q;
   logic         out_last_q;
   logic         done_q;
   logic         err_q;
   logic [0:63]  msg_len_q;

   logic [63:0]  len_s;
   logic [8:0]   len9_s;
   logic [5:0]   nbytes_s;
   logic [5:0]   idx_d;
   logic         valid_s;

   // Marker must sit exactly at bit len and everything after it up to the
   // length field must be zero.
   function automatic logic pad_ok_f(input logic [0:511] blk, input logic [8:0] len);
      logic ok;
      ok = blk[len];
      for (int i = 0; i < 448; i++) begin
         if ((i > int'(len)) && blk[i]) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

   assign len_s    = msg_len_q;
   assign len9_s   = len_s[8:0];
   assign nbytes_s = len9_s[8:3];
   assign idx_d    = idx_q + 6'd1;
   assign valid_s  = (len_s[63:9] == 55'd0) && (len9_s <= MAX_BITS) &&
                     (len9_s[2:0] == 3'd0) && pad_ok_f(blk_q, len9_s);

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_byte  = out_byte_q;
   assign out_last  = out_last_q;
   assign done      = done_q;
   assign err       = err_q;
   assign msg_len   = msg_len_q;

   // Control FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         blk_q       <= '0;
         idx_q       <= 6'd0;
         last_idx_q  <= 6'd0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_byte_q  <= 8'd0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         msg_len_q   <= 64'd0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (in_valid && in_ready_q) begin
                  blk_q      <= messageBlock;
                  msg_len_q  <= messageBlock[448:511];
                  idx_q      <= 6'd0;
                  err_q      <= 1'b0;
                  in_ready_q <= 1'b0;
                  state_q    <= CHECK;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            CHECK: begin
               if (!valid_s) begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (nbytes_s == 6'd0) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  out_valid_q <= 1'b1;
                  out_byte_q  <= blk_q[0:7];
                  out_last_q  <= (nbytes_s == 6'd1);
                  last_idx_q  <= nbytes_s - 6'd1;
                  state_q     <= EMIT;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (out_last_q) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     out_byte_q  <= 8'd0;
                     done_q      <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     idx_q      <= idx_d;
                     out_byte_q <= blk_q[{idx_d, 3'b000} +: 8];
                     out_last_q <= (idx_d == last_idx_q);
                  end
               end
            end
            DONE: begin
               done_q     <= 1'b0;
               in_ready_q <= 1'b1;
               state_q    <= IDLE;
            end
            default: begin
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
               done_q      <= 1'b0;
               in_ready_q  <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

endmodule
